cook_sequencer: RTL and testbench

//  Top-level controller for the microwave cook cycle. It takes debounced keypad digits
//  and builds an M:SS preset. It then sequences the countdown timer (parallel load,

---
 rtl/microwave_pkg.sv | 24 ++
 rtl/cook_sequencer_if.sv | 36 +++
 rtl/digit_entry_reg.sv | 48 ++++
 rtl/cook_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_cook_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave cook controller.
package microwave_pkg;

    // Controller state; the encoding is visible on the debug state output
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENTRY  = 3'd1,
        COOK   = 3'd2,
        PAUSED = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int unsigned MAX_TENS  = 5;
    localparam int unsigned MAX_DIGIT = 9;

    localparam int unsigned DEF_POWER_LEVELS = 10;
    localparam int unsigned DEF_BEEP_SECONDS = 3;

    // Power steps downward; level 1 wraps back to the top level
    function automatic logic [3:0] power_step(input logic [3:0] lvl, input int unsigned levels);
        return (lvl <= 4'd1) ? 4'(levels) : lvl - 4'd1;
    endfunction

endpackage

// File: rtl/cook_sequencer_if.sv
// Keypad, prescaler, timer and display signals of the cook controller.
interface cook_sequencer_if;
    logic       tick_1hz;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start_btn;
    logic       stop_btn;
    logic       power_btn;
    logic       closed_door;
    logic       timer_zero;
    logic [3:0] preset_units;
    logic [3:0] preset_tens;
    logic [3:0] preset_minutes;
    logic       timer_load;
    logic       timer_en;
    logic       magnetron;
    logic [3:0] power_level;
    logic       beep;
    logic [2:0] state;

    // Surrounding system drives the inputs and observes the outputs
    modport master (
        output tick_1hz, key_valid, key_digit, start_btn, stop_btn, power_btn,
               closed_door, timer_zero,
        input  preset_units, preset_tens, preset_minutes, timer_load, timer_en,
               magnetron, power_level, beep, state
    );

    // Cook controller side
    modport slave (
        input  tick_1hz, key_valid, key_digit, start_btn, stop_btn, power_btn,
               closed_door, timer_zero,
        output preset_units, preset_tens, preset_minutes, timer_load, timer_en,
               magnetron, power_level, beep, state
    );
endinterface

// File: rtl/digit_entry_reg.sv
// Three-digit M:SS preset shift register with the tens<=5 entry rule.
module digit_entry_reg
    import microwave_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       i_shift,
    input  logic [3:0] i_digit,
    input  logic       i_clr_presets,
    output logic       o_key_ok,
    output logic       o_nonzero,
    output logic [3:0] o_units,
    output logic [3:0] o_tens,
    output logic [3:0] o_minutes
);

    logic [3:0] r_units;
    logic [3:0] r_tens;
    logic [3:0] r_minutes;
    logic       w_do_shift;

    // Units shift into tens, so a units digit above 5 would make an illegal tens digit
    assign o_key_ok   = (r_units <= 4'(MAX_TENS)) && (i_digit <= 4'(MAX_DIGIT));
    assign w_do_shift = i_shift && o_key_ok;
    assign o_nonzero  = |{r_minutes, r_tens, r_units};

    // Shift in a new digit from the right; the old minutes digit falls off
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_units   <= 4'd0;
            r_tens    <= 4'd0;
            r_minutes <= 4'd0;
        end else if (i_clr_presets) begin
            r_units   <= 4'd0;
            r_tens    <= 4'd0;
            r_minutes <= 4'd0;
        end else if (w_do_shift) begin
            r_minutes <= r_tens;
            r_tens    <= r_units;
            r_units   <= i_digit;
        end
    end

    assign o_units   = r_units;
    assign o_tens    = r_tens;
    assign o_minutes = r_minutes;

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook cycle controller: preset entry, timer sequencing, magnetron duty and beep.
module cook_sequencer
    import microwave_pkg::*;
#(
    parameter int unsigned POWER_LEVELS = DEF_POWER_LEVELS,
    parameter int unsigned BEEP_SECONDS = DEF_BEEP_SECONDS
) (
    input logic             clk,
    input logic             clear,
    cook_sequencer_if.slave bus
);

    localparam int unsigned BEEP_W = (BEEP_SECONDS > 1) ? $clog2(BEEP_SECONDS) : 1;
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_SECONDS - 1);
    localparam logic [3:0]        DUTY_LAST = 4'(POWER_LEVELS - 1);
    localparam logic [3:0]        POWER_MAX = 4'(POWER_LEVELS);

    state_e            r_state;
    state_e            w_state_d;
    logic              w_load;
    logic              w_key_shift;
    logic              w_power_step;
    logic              w_clr_presets;
    logic              w_key_ok;
    logic              w_nonzero;

    logic [3:0]        r_duty_cnt;
    logic [3:0]        w_duty_d;
    logic [BEEP_W-1:0] r_beep_cnt;
    logic [BEEP_W-1:0] w_beep_d;
    logic [3:0]        r_power_level;
    logic [3:0]        w_power_d;

    logic              r_timer_load;
    logic              r_timer_en;
    logic              r_magnetron;
    logic              r_beep;
    logic              w_timer_load_d;
    logic              w_timer_en_d;
    logic              w_magnetron_d;
    logic              w_beep_d_out;

    logic [3:0]        w_units;
    logic [3:0]        w_tens;
    logic [3:0]        w_minutes;

    digit_entry_reg u_digits (
        .clk           (clk),
        .clear         (clear),
        .i_shift       (w_key_shift),
        .i_digit       (bus.key_digit),
        .i_clr_presets (w_clr_presets),
        .o_key_ok      (w_key_ok),
        .o_nonzero     (w_nonzero),
        .o_units       (w_units),
        .o_tens        (w_tens),
        .o_minutes     (w_minutes)
    );

    // State register
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state and the single-cycle actions it implies
    always_comb begin
        w_state_d    = r_state;
        w_load       = 1'b0;
        w_key_shift  = 1'b0;
        w_power_step = 1'b0;
        unique case (r_state)
            IDLE, ENTRY: begin
                if (bus.stop_btn) begin
                    w_state_d = IDLE;
                end else if (bus.start_btn) begin
                    // A key arriving with start is dropped; start uses the old preset
                    if (r_state == ENTRY && bus.closed_door && w_nonzero) begin
                        w_state_d = COOK;
                        w_load    = 1'b1;
                    end
                end else if (bus.key_valid) begin
                    if (w_key_ok) begin
                        w_key_shift = 1'b1;
                        w_state_d   = ENTRY;
                    end
                end else if (bus.power_btn) begin
                    w_power_step = 1'b1;
                end
            end
            COOK: begin
                // Only trust timer_zero once the timer has actually been counting
                if (bus.timer_zero && r_timer_en) begin
                    w_state_d = DONE;
                end else if (bus.stop_btn || !bus.closed_door) begin
                    w_state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (bus.stop_btn) begin
                    w_state_d = IDLE;
                end else if (bus.start_btn && bus.closed_door) begin
                    w_state_d = COOK;
                end
            end
            DONE: begin
                if (bus.stop_btn || !bus.closed_door) begin
                    w_state_d = IDLE;
                end else if (bus.tick_1hz && r_beep_cnt == BEEP_LAST) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Every return to IDLE leaves the preset at 0:00
    assign w_clr_presets = (w_state_d == IDLE);

    // Duty, beep and power next values
    always_comb begin
        w_duty_d  = r_duty_cnt;
        w_beep_d  = r_beep_cnt;
        w_power_d = r_power_level;
        if (w_load) begin
            w_duty_d = 4'd0;
        end else if (r_state == COOK && w_state_d == COOK && bus.tick_1hz) begin
            w_duty_d = (r_duty_cnt == DUTY_LAST) ? 4'd0 : r_duty_cnt + 4'd1;
        end
        if (w_state_d == DONE && r_state != DONE) begin
            w_beep_d = '0;
        end else if (r_state == DONE && w_state_d == DONE && bus.tick_1hz) begin
            w_beep_d = r_beep_cnt + BEEP_W'(1);
        end
        if (w_power_step) begin
            w_power_d = power_step(r_power_level, POWER_LEVELS);
        end
    end

    // Duty, beep and power registers
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_duty_cnt    <= 4'd0;
            r_beep_cnt    <= '0;
            r_power_level <= POWER_MAX;
        end else begin
            r_duty_cnt    <= w_duty_d;
            r_beep_cnt    <= w_beep_d;
            r_power_level <= w_power_d;
        end
    end

    // Output next values, derived from the state being entered
    always_comb begin
        w_timer_load_d = w_load;
        // On the load cycle the timer is not yet enabled; it counts from the next clk
        w_timer_en_d   = (w_state_d == COOK) && !w_load;
        // Door term is redundant with the FSM but keeps the interlock local
        w_magnetron_d  = (w_state_d == COOK) && bus.closed_door && (w_duty_d < r_power_level);
        w_beep_d_out   = (w_state_d == DONE);
    end

    // Output registers
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_timer_load <= 1'b0;
            r_timer_en   <= 1'b0;
            r_magnetron  <= 1'b0;
            r_beep       <= 1'b0;
        end else begin
            r_timer_load <= w_timer_load_d;
            r_timer_en   <= w_timer_en_d;
            r_magnetron  <= w_magnetron_d;
            r_beep       <= w_beep_d_out;
        end
    end

    assign bus.preset_units   = w_units;
    assign bus.preset_tens    = w_tens;
    assign bus.preset_minutes = w_minutes;
    assign bus.timer_load     = r_timer_load;
    assign bus.timer_en       = r_timer_en;
    assign bus.magnetron      = r_magnetron;
    assign bus.power_level    = r_power_level;
    assign bus.beep           = r_beep;
    assign bus.state          = r_state;

endmodule

// File: tb/tb_cook_sequencer.sv
// Scoreboard bench for cook_sequencer: a behavioural model predicts every clk's outputs.
module tb_cook_sequencer;

    localparam int PL = 10;
    localparam int BS = 3;

    localparam int M_IDLE   = 0;
    localparam int M_ENTRY  = 1;
    localparam int M_COOK   = 2;
    localparam int M_PAUSED = 3;
    localparam int M_DONE   = 4;

    typedef struct packed {
        logic [2:0] state;
        logic [3:0] minutes;
        logic [3:0] tens;
        logic [3:0] units;
        logic       load;
        logic       en;
        logic       mag;
        logic [3:0] power;
        logic       beep;
    } snap_t;

    logic clk = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    cook_sequencer_if bus_if ();

    cook_sequencer #(
        .POWER_LEVELS (PL),
        .BEEP_SECONDS (BS)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus_if)
    );

    snap_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Model of the cook cycle, held as plain numbers
    int m_state, m_min, m_ten, m_unit, m_power, m_duty, m_beep_left;
    bit m_load, m_en, m_mag, m_beep;
    bit m_door = 1'b1;
    bit m_tz = 1'b0;

    task automatic model_reset();
        m_state = M_IDLE;
        m_min = 0; m_ten = 0; m_unit = 0;
        m_power = PL; m_duty = 0; m_beep_left = 0;
        m_load = 0; m_en = 0; m_mag = 0; m_beep = 0;
    endtask

    task automatic go_idle();
        m_state = M_IDLE;
        m_min = 0; m_ten = 0; m_unit = 0;
    endtask

    task automatic model_step(input bit tk, input bit kv, input int kd,
                              input bit st, input bit sp, input bit pw);
        bit load = 1'b0;
        int secs = m_min * 60 + m_ten * 10 + m_unit;
        case (m_state)
            M_IDLE, M_ENTRY: begin
                if (sp) go_idle();
                else if (st) begin
                    if (m_state == M_ENTRY && m_door && secs != 0) begin
                        m_state = M_COOK; load = 1'b1; m_duty = 0;
                    end
                end else if (kv) begin
                    if (m_unit <= 5) begin
                        m_min = m_ten; m_ten = m_unit; m_unit = kd; m_state = M_ENTRY;
                    end
                end else if (pw) m_power = (m_power == 1) ? PL : m_power - 1;
            end
            M_COOK: begin
                if (m_tz && m_en) begin
                    m_state = M_DONE; m_beep_left = BS;
                end else if (sp || !m_door) m_state = M_PAUSED;
                else if (tk) m_duty = (m_duty + 1) % PL;
            end
            M_PAUSED: begin
                if (sp) go_idle();
                else if (st && m_door) m_state = M_COOK;
            end
            M_DONE: begin
                if (sp || !m_door) go_idle();
                else if (tk) begin
                    m_beep_left = m_beep_left - 1;
                    if (m_beep_left == 0) go_idle();
                end
            end
            default: ;
        endcase
        m_load = load;
        m_en   = (m_state == M_COOK) && !load;
        m_mag  = (m_state == M_COOK) && (m_duty < m_power);
        m_beep = (m_state == M_DONE);
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.state = 3'(m_state); s.minutes = 4'(m_min); s.tens = 4'(m_ten); s.units = 4'(m_unit);
        s.load = m_load; s.en = m_en; s.mag = m_mag; s.power = 4'(m_power); s.beep = m_beep;
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.state = bus_if.state; s.minutes = bus_if.preset_minutes;
        s.tens = bus_if.preset_tens; s.units = bus_if.preset_units;
        s.load = bus_if.timer_load; s.en = bus_if.timer_en; s.mag = bus_if.magnetron;
        s.power = bus_if.power_level; s.beep = bus_if.beep;
        return s;
    endfunction

    task automatic drive(input bit tk, input bit kv, input int kd,
                         input bit st, input bit sp, input bit pw);
        bus_if.tick_1hz    = tk;
        bus_if.key_valid   = kv;
        bus_if.key_digit   = 4'(kd);
        bus_if.start_btn   = st;
        bus_if.stop_btn    = sp;
        bus_if.power_btn   = pw;
        bus_if.closed_door = m_door;
        bus_if.timer_zero  = m_tz;
    endtask

    // One clk of stimulus; the expected post-edge outputs go on the scoreboard
    task automatic cyc(input bit tk, input bit kv, input int kd,
                       input bit st, input bit sp, input bit pw);
        @(negedge clk);
        clear = 1'b0;
        drive(tk, kv, kd, st, sp, pw);
        model_step(tk, kv, kd, st, sp, pw);
        exp_q.push_back(model_snap());
    endtask

    // Assert clear between edges and check that outputs drop without waiting for a clk
    task automatic do_clear();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        clear = 1'b1;
        #1;
        n_cmp++;
        if (bus_if.magnetron !== 1'b0 || bus_if.timer_en !== 1'b0 || bus_if.beep !== 1'b0 ||
            bus_if.state !== 3'd0 || bus_if.timer_load !== 1'b0) begin
            n_bad++;
            $display("FAIL async_clear: got mag=%b en=%b load=%b beep=%b state=%0d, required all 0",
                     bus_if.magnetron, bus_if.timer_en, bus_if.timer_load, bus_if.beep,
                     bus_if.state);
        end
        model_reset();
        exp_q.push_back(model_snap());
    endtask

    task automatic key(input int d);  cyc(0, 1, d, 0, 0, 0); endtask
    task automatic start();           cyc(0, 0, 0, 1, 0, 0); endtask
    task automatic stop();            cyc(0, 0, 0, 0, 1, 0); endtask
    task automatic power();           cyc(0, 0, 0, 0, 0, 1); endtask
    task automatic idle(input int n); for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0); endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            idle(1);
        end
    endtask

    // Monitor: every clk the DUT presents a fresh registered snapshot
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                snap_t e;
                snap_t a;
                e = exp_q.pop_front();
                a = dut_snap();
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display({"FAIL outputs @%0t: got st=%0d preset=%0d:%0d%0d ld=%b en=%b mag=%b ",
                              "pwr=%0d beep=%b | required st=%0d preset=%0d:%0d%0d ld=%b en=%b ",
                              "mag=%b pwr=%0d beep=%b"},
                             $time, a.state, a.minutes, a.tens, a.units, a.load, a.en, a.mag,
                             a.power, a.beep, e.state, e.minutes, e.tens, e.units, e.load, e.en,
                             e.mag, e.power, e.beep);
                end
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #1 clear = 1'b1;
        do_clear();
        do_clear();

        // Build 1:30 and start with the door closed
        key(1); key(3); key(0);
        start();
        idle(2);
        ticks(3);
        stop();
        stop();

        // Second key rejected while units is 7
        key(7); key(9); idle(1);
        stop();

        // Power 7 then watch the duty window over more than two periods
        power(); power(); power();
        key(5);
        start();
        ticks(22);

        // Door opens mid-cook, then close and resume without a reload
        m_door = 1'b0;
        idle(2);
        m_door = 1'b1;
        idle(1);
        start();
        ticks(2);

        // Timer reaches zero: beep for three ticks then back to IDLE
        m_tz = 1'b1;
        idle(2);
        m_tz = 1'b0;
        ticks(3);
        idle(2);

        // Starts that must be ignored, and stop+start together in PAUSED
        start();
        key(0); start(); stop();
        key(2);
        m_door = 1'b0;
        start();
        m_door = 1'b1;
        start();
        stop();
        cyc(0, 0, 0, 1, 1, 0);

        // Start with a key in the same clk keeps the old preset; then clear mid-cook
        key(4);
        cyc(0, 1, 6, 1, 0, 0);
        ticks(2);
        do_clear();
        idle(2);

        // Power wrap from 1 back to the top
        for (int i = 0; i < PL + 2; i++) power();

        // Randomised traffic, including simultaneous buttons
        m_door = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bit tk, kv, st, sp, pw;
            int kd;
            if ($urandom_range(0, 29) == 0) m_door = ~m_door;
            m_tz = ($urandom_range(0, 19) == 0);
            tk = ($urandom_range(0, 3) == 0);
            kv = ($urandom_range(0, 3) == 0);
            kd = int'($urandom_range(0, 9));
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 15) == 0);
            pw = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) do_clear();
            else cyc(tk, kv, kd, st, sp, pw);
        end

        idle(2);
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
